// File: rtl/osc_trig_pkg.sv
// Shared definitions for the oscilloscope edge trigger unit.
// Holds the trigger FSM state encoding, the i_mode encodings and the
// default parameter values used by edge_trigger_unit and its sub-module.
package osc_trig_pkg;

  localparam int DEFAULT_DATA_W    = 12;
  localparam int DEFAULT_PRETRIG_W = 10;
  localparam int DEFAULT_HOLDOFF_W = 16;
  localparam int DEFAULT_TCOUNT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRETRIG   = 3'd1,
    ST_ARMED     = 3'd2,
    ST_TRIGGERED = 3'd3,
    ST_HOLDOFF   = 3'd4
  } trig_state_e;

  localparam logic [1:0] MODE_RISING  = 2'b00;
  localparam logic [1:0] MODE_FALLING = 2'b01;
  localparam logic [1:0] MODE_EITHER  = 2'b10;
  localparam logic [1:0] MODE_LEVEL   = 2'b11;

endpackage

// File: rtl/hysteresis_comparator.sv
// Schmitt-trigger comparator for the edge trigger unit.
// Ports:
//   i_clk, i_reset     clock and synchronous active-high reset
//   i_valid            i_sample carries a sample this cycle
//   i_sample           unsigned sample
//   i_level            upper threshold (flag sets at or above it)
//   i_hysteresis       band below i_level; flag clears below level-hysteresis
//   o_flag             registered Schmitt flag
//   o_flag_next        flag value after the current sample is applied
//   o_primed           set once any valid sample has been seen since reset
module hysteresis_comparator
  import osc_trig_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_sample,
  input  logic [DATA_W-1:0] i_level,
  input  logic [DATA_W-1:0] i_hysteresis,
  output logic              o_flag,
  output logic              o_flag_next,
  output logic              o_primed
);

  // Lower threshold floors at zero so a hysteresis larger than the level
  // never wraps into a huge bound.
  function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return (b > a) ? '0 : (a - b);
  endfunction

  logic              flag_q, flag_d;
  logic              primed_q, primed_d;
  logic [DATA_W-1:0] lower;

  always_comb begin
    lower    = sat_sub(i_level, i_hysteresis);
    flag_d   = flag_q;
    primed_d = primed_q | i_valid;
    if (i_valid) begin
      if (i_sample >= i_level) begin
        flag_d = 1'b1;
      end else if (i_sample < lower) begin
        flag_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      flag_q   <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      flag_q   <= flag_d;
      primed_q <= primed_d;
    end
  end

  assign o_flag      = flag_q;
  assign o_flag_next = flag_d;
  assign o_primed    = primed_q;

endmodule

// File: rtl/edge_trigger_unit.sv
// Oscilloscope edge trigger unit.
// Arms on i_arm, collects a pre-trigger quota of valid samples, then fires a
// one-cycle o_trigger on the selected edge of a hysteresis-filtered compare.
// After the downstream transfer completes it pulses o_capture_reset, waits a
// holdoff and either re-arms or returns to IDLE.
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_response_valid           i_sample_data valid this cycle
//   i_sample_data              unsigned ADC sample
//   i_level, i_hysteresis      trigger threshold and band below it
//   i_mode                     00 rising, 01 falling, 10 either, 11 level-above
//   i_arm, i_auto_rearm        start from IDLE / re-arm after holdoff
//   i_pretrig_count            valid samples needed before arming
//   i_holdoff                  post-transfer dead time in cycles
//   i_transfer_done            downstream capture done (aborts if not triggered)
//   o_trigger                  one-cycle trigger pulse
//   o_capture_reset            one-cycle capture-buffer reset pulse
//   o_armed, o_busy            state is ARMED / state is not IDLE
//   o_trig_count               triggers since reset, wrapping
module edge_trigger_unit
  import osc_trig_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int PRETRIG_W = DEFAULT_PRETRIG_W,
  parameter int HOLDOFF_W = DEFAULT_HOLDOFF_W,
  parameter int TCOUNT_W  = DEFAULT_TCOUNT_W
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_response_valid,
  input  logic [DATA_W-1:0]    i_sample_data,
  input  logic [DATA_W-1:0]    i_level,
  input  logic [DATA_W-1:0]    i_hysteresis,
  input  logic [1:0]           i_mode,
  input  logic                 i_arm,
  input  logic                 i_auto_rearm,
  input  logic [PRETRIG_W-1:0] i_pretrig_count,
  input  logic [HOLDOFF_W-1:0] i_holdoff,
  input  logic                 i_transfer_done,
  output logic                 o_trigger,
  output logic                 o_capture_reset,
  output logic                 o_armed,
  output logic                 o_busy,
  output logic [TCOUNT_W-1:0]  o_trig_count
);

  trig_state_e          state_q, state_d;
  logic [PRETRIG_W-1:0] pcnt_q, pcnt_d;
  logic [HOLDOFF_W-1:0] hcnt_q, hcnt_d;
  logic [TCOUNT_W-1:0]  trig_cnt_q, trig_cnt_d;
  logic                 trig_q, trig_d;
  logic                 caprst_q, caprst_d;
  logic                 armed_q, armed_d;
  logic                 busy_q, busy_d;

  // Run configuration, captured on every entry to PRETRIG.
  logic [DATA_W-1:0]    level_q, level_d;
  logic [DATA_W-1:0]    hyst_q, hyst_d;
  logic [1:0]           mode_q, mode_d;
  logic [PRETRIG_W-1:0] pretrig_q, pretrig_d;
  logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;

  logic flag, flag_next, primed;
  logic rise, fall, qualify;
  logic enter_pretrig;

  hysteresis_comparator #(
    .DATA_W(DATA_W)
  ) u_cmp (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_valid      (i_response_valid),
    .i_sample     (i_sample_data),
    .i_level      (level_q),
    .i_hysteresis (hyst_q),
    .o_flag       (flag),
    .o_flag_next  (flag_next),
    .o_primed     (primed)
  );

  // Edges need a prior sample to compare against, hence the primed gate.
  always_comb begin
    rise    = primed & ~flag & flag_next;
    fall    = primed & flag & ~flag_next;
    qualify = 1'b0;
    case (mode_q)
      MODE_RISING:  qualify = i_response_valid & rise;
      MODE_FALLING: qualify = i_response_valid & fall;
      MODE_EITHER:  qualify = i_response_valid & (rise | fall);
      default:      qualify = i_response_valid & flag_next;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    pcnt_d        = pcnt_q;
    hcnt_d        = hcnt_q;
    trig_cnt_d    = trig_cnt_q;
    trig_d        = 1'b0;
    caprst_d      = 1'b0;
    level_d       = level_q;
    hyst_d        = hyst_q;
    mode_d        = mode_q;
    pretrig_d     = pretrig_q;
    holdoff_d     = holdoff_q;
    enter_pretrig = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_arm) begin
          enter_pretrig = 1'b1;
        end
      end
      ST_PRETRIG: begin
        if (i_transfer_done) begin
          state_d  = ST_IDLE;
          caprst_d = 1'b1;
        end else if (pretrig_q == '0) begin
          state_d = ST_ARMED;
        end else if (i_response_valid) begin
          pcnt_d = pcnt_q + PRETRIG_W'(1);
          if (pcnt_d == pretrig_q) begin
            state_d = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        // Abort has priority over a coincident qualifying sample.
        if (i_transfer_done) begin
          state_d  = ST_IDLE;
          caprst_d = 1'b1;
        end else if (qualify) begin
          state_d    = ST_TRIGGERED;
          trig_d     = 1'b1;
          trig_cnt_d = trig_cnt_q + TCOUNT_W'(1);
        end
      end
      ST_TRIGGERED: begin
        if (i_transfer_done) begin
          state_d  = ST_HOLDOFF;
          caprst_d = 1'b1;
          hcnt_d   = '0;
        end
      end
      ST_HOLDOFF: begin
        if (hcnt_q == holdoff_q) begin
          if (i_auto_rearm) begin
            enter_pretrig = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hcnt_d = hcnt_q + HOLDOFF_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (enter_pretrig) begin
      state_d   = ST_PRETRIG;
      pcnt_d    = '0;
      level_d   = i_level;
      hyst_d    = i_hysteresis;
      mode_d    = i_mode;
      pretrig_d = i_pretrig_count;
      holdoff_d = i_holdoff;
    end

    armed_d = (state_d == ST_ARMED);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      pcnt_q     <= '0;
      hcnt_q     <= '0;
      trig_cnt_q <= '0;
      trig_q     <= 1'b0;
      caprst_q   <= 1'b0;
      armed_q    <= 1'b0;
      busy_q     <= 1'b0;
      level_q    <= '0;
      hyst_q     <= '0;
      mode_q     <= MODE_RISING;
      pretrig_q  <= '0;
      holdoff_q  <= '0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      hcnt_q     <= hcnt_d;
      trig_cnt_q <= trig_cnt_d;
      trig_q     <= trig_d;
      caprst_q   <= caprst_d;
      armed_q    <= armed_d;
      busy_q     <= busy_d;
      level_q    <= level_d;
      hyst_q     <= hyst_d;
      mode_q     <= mode_d;
      pretrig_q  <= pretrig_d;
      holdoff_q  <= holdoff_d;
    end
  end

  assign o_trigger       = trig_q;
  assign o_capture_reset = caprst_q;
  assign o_armed         = armed_q;
  assign o_busy          = busy_q;
  assign o_trig_count    = trig_cnt_q;

endmodule

// File: tb/tb_edge_trigger_unit.sv
module tb_edge_trigger_unit;
  import osc_trig_pkg::*;

  localparam int DATA_W    = 12;
  localparam int PRETRIG_W = 10;
  localparam int HOLDOFF_W = 16;
  localparam int TCOUNT_W  = 16;

  logic                 i_clk;
  logic                 i_reset;
  logic                 i_response_valid;
  logic [DATA_W-1:0]    i_sample_data;
  logic [DATA_W-1:0]    i_level;
  logic [DATA_W-1:0]    i_hysteresis;
  logic [1:0]           i_mode;
  logic                 i_arm;
  logic                 i_auto_rearm;
  logic [PRETRIG_W-1:0] i_pretrig_count;
  logic [HOLDOFF_W-1:0] i_holdoff;
  logic                 i_transfer_done;
  logic                 o_trigger;
  logic                 o_capture_reset;
  logic                 o_armed;
  logic                 o_busy;
  logic [TCOUNT_W-1:0]  o_trig_count;

  edge_trigger_unit #(
    .DATA_W(DATA_W), .PRETRIG_W(PRETRIG_W), .HOLDOFF_W(HOLDOFF_W), .TCOUNT_W(TCOUNT_W)
  ) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_response_valid (i_response_valid),
    .i_sample_data    (i_sample_data),
    .i_level          (i_level),
    .i_hysteresis     (i_hysteresis),
    .i_mode           (i_mode),
    .i_arm            (i_arm),
    .i_auto_rearm     (i_auto_rearm),
    .i_pretrig_count  (i_pretrig_count),
    .i_holdoff        (i_holdoff),
    .i_transfer_done  (i_transfer_done),
    .o_trigger        (o_trigger),
    .o_capture_reset  (o_capture_reset),
    .o_armed          (o_armed),
    .o_busy           (o_busy),
    .o_trig_count     (o_trig_count)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit is_trig;
    int cnt;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_trig(input int cnt);
    ev_t e;
    e.is_trig = 1'b1;
    e.cnt     = cnt;
    exp_q.push_back(e);
  endtask

  task automatic push_cap();
    ev_t e;
    e.is_trig = 1'b0;
    e.cnt     = 0;
    exp_q.push_back(e);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  always @(negedge i_clk) begin
    ev_t e;
    if (o_trigger) begin
      checks++;
      if (exp_q.size() == 0 || !exp_q[0].is_trig) begin
        errors++;
        $display("FAIL trigger_pulse actual=unexpected_trigger required=no_trigger");
        if (exp_q.size() != 0) e = exp_q.pop_front();
      end else begin
        e = exp_q.pop_front();
        chk("trigger_count_at_pulse", o_trig_count, e.cnt);
      end
    end
    if (o_capture_reset) begin
      checks++;
      if (exp_q.size() == 0 || exp_q[0].is_trig) begin
        errors++;
        $display("FAIL capture_reset_pulse actual=unexpected_capture_reset required=none");
        if (exp_q.size() != 0) e = exp_q.pop_front();
      end else begin
        e = exp_q.pop_front();
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic samp(input int v);
    i_response_valid = 1'b1;
    i_sample_data    = DATA_W'(v);
    tick();
    i_response_valid = 1'b0;
  endtask

  task automatic done();
    i_transfer_done = 1'b1;
    tick();
    i_transfer_done = 1'b0;
  endtask

  task automatic arm_cfg(input logic [1:0] mode, input int level, input int hyst,
                         input int pre, input int hold);
    i_mode          = mode;
    i_level         = DATA_W'(level);
    i_hysteresis    = DATA_W'(hyst);
    i_pretrig_count = PRETRIG_W'(pre);
    i_holdoff       = HOLDOFF_W'(hold);
    i_arm           = 1'b1;
    tick();
    i_arm           = 1'b0;
  endtask

  initial begin
    i_reset          = 1'b1;
    i_response_valid = 1'b0;
    i_sample_data    = '0;
    i_level          = '0;
    i_hysteresis     = '0;
    i_mode           = MODE_RISING;
    i_arm            = 1'b0;
    i_auto_rearm     = 1'b0;
    i_pretrig_count  = '0;
    i_holdoff        = '0;
    i_transfer_done  = 1'b0;
    tick();
    tick();
    chk("reset_trigger", o_trigger, 0);
    chk("reset_capture_reset", o_capture_reset, 0);
    chk("reset_armed", o_armed, 0);
    chk("reset_busy", o_busy, 0);
    chk("reset_count", o_trig_count, 0);
    i_reset = 1'b0;

    // Basic rising trigger, pretrig 0
    arm_cfg(MODE_RISING, 1500, 50, 0, 0);
    chk("pretrig_busy", o_busy, 1);
    chk("pretrig_not_armed", o_armed, 0);
    tick();
    chk("armed_after_zero_pretrig", o_armed, 1);
    samp(1400);
    push_trig(1);
    samp(1501);
    chk("count_after_first_trigger", o_trig_count, 1);
    chk("armed_drops_on_trigger", o_armed, 0);
    tick();
    chk("trigger_one_cycle", o_trigger, 0);
    push_cap();
    done();
    chk("holdoff_busy", o_busy, 1);
    tick();
    chk("idle_after_zero_holdoff", o_busy, 0);

    // Hysteresis, then holdoff 10 with auto re-arm
    i_auto_rearm = 1'b1;
    arm_cfg(MODE_RISING, 1500, 50, 0, 10);
    tick();
    chk("rearm_armed", o_armed, 1);
    samp(1501);
    samp(1460);
    samp(1502);
    samp(1440);
    chk("no_retrigger_inside_band", o_trig_count, 1);
    push_trig(2);
    samp(1500);
    chk("count_after_hyst_trigger", o_trig_count, 2);
    tick();
    push_cap();
    done();
    repeat (10) tick();
    chk("holdoff_not_armed", o_armed, 0);
    chk("holdoff_still_busy", o_busy, 1);
    tick();
    chk("pretrig_after_11_cycles_not_armed", o_armed, 0);
    tick();
    chk("armed_after_auto_rearm", o_armed, 1);

    // Abort beats coincident qualifying sample
    i_auto_rearm = 1'b0;
    samp(1400);
    push_cap();
    i_transfer_done = 1'b1;
    samp(1600);
    i_transfer_done = 1'b0;
    chk("abort_idle", o_busy, 0);
    chk("abort_count_unchanged", o_trig_count, 2);
    chk("abort_no_trigger", o_trigger, 0);

    // Pretrig quota of 4 valid samples
    arm_cfg(MODE_RISING, 1500, 50, 4, 0);
    samp(1400);
    tick();
    samp(1400);
    samp(1600);
    chk("no_arm_after_3_samples", o_armed, 0);
    tick();
    chk("invalid_cycle_not_counted", o_armed, 0);
    samp(1600);
    chk("armed_after_4_samples", o_armed, 1);
    chk("no_trigger_in_pretrig", o_trig_count, 2);
    samp(1400);
    push_trig(3);
    samp(1550);
    chk("count_after_pretrig_run", o_trig_count, 3);

    // Reset while TRIGGERED
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("midrun_reset_trigger", o_trigger, 0);
    chk("midrun_reset_capture_reset", o_capture_reset, 0);
    chk("midrun_reset_armed", o_armed, 0);
    chk("midrun_reset_busy", o_busy, 0);
    chk("midrun_reset_count", o_trig_count, 0);

    // Either-edge: first sample after reset is unprimed
    arm_cfg(MODE_EITHER, 1500, 50, 0, 0);
    tick();
    samp(1600);
    chk("unprimed_no_trigger", o_trig_count, 0);
    push_trig(1);
    samp(1400);
    push_cap();
    done();
    tick();

    // Level-above at exactly the level
    arm_cfg(MODE_LEVEL, 1500, 50, 0, 0);
    tick();
    samp(1400);
    push_trig(2);
    samp(1500);
    push_cap();
    done();
    tick();

    // Falling edge at lower hysteresis bound
    arm_cfg(MODE_FALLING, 1500, 50, 0, 0);
    tick();
    samp(1451);
    samp(1450);
    chk("no_fall_at_lower_bound", o_trig_count, 2);
    push_trig(3);
    samp(1449);
    push_cap();
    done();
    tick();

    // Hysteresis larger than level: lower bound saturates to 0
    arm_cfg(MODE_EITHER, 20, 50, 0, 0);
    tick();
    push_trig(4);
    samp(25);
    push_cap();
    done();
    tick();
    arm_cfg(MODE_EITHER, 20, 50, 0, 0);
    tick();
    samp(0);
    samp(5);
    chk("saturated_bound_no_clear", o_trig_count, 4);
    push_cap();
    done();
    chk("abort_from_armed_idle", o_busy, 0);

    // Abort from PRETRIG
    arm_cfg(MODE_RISING, 1500, 50, 4, 0);
    push_cap();
    done();
    chk("abort_from_pretrig_idle", o_busy, 0);

    repeat (3) tick();
    chk("pending_expectations", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/edge_trigger_unit.md
EDGE_TRIGGER_UNIT -- requirements
Module: edge_trigger_unit

Interface
REQ-001 Parameter DATA_W, default 12: sample, level and hysteresis width.
REQ-002 Parameter PRETRIG_W, default 10: pre-trigger sample counter width.
REQ-003 Parameter HOLDOFF_W, default 16: holdoff cycle counter width.
REQ-004 Parameter TCOUNT_W, default 16: trigger event counter width.
REQ-005 i_clk  in  1  sole clock; all logic on rising edge.
REQ-006 i_reset  in  1  synchronous, active-high reset.
REQ-007 i_response_valid  in  1  i_sample_data valid this cycle.
REQ-008 i_sample_data  in  DATA_W  unsigned ADC sample.
REQ-009 i_level  in  DATA_W  trigger threshold.
REQ-010 i_hysteresis  in  DATA_W  hysteresis band below i_level.
REQ-011 i_mode  in  2  00 rising, 01 falling, 10 either edge, 11 level-above.
REQ-012 i_arm  in  1  start acquisition from IDLE.
REQ-013 i_auto_rearm  in  1  re-arm after holdoff instead of idling.
REQ-014 i_pretrig_count  in  PRETRIG_W  valid samples required before arming.
REQ-015 i_holdoff  in  HOLDOFF_W  post-transfer dead time, in cycles.
REQ-016 i_transfer_done  in  1  downstream capture transfer complete.
REQ-017 o_trigger  out  1  one-cycle trigger pulse.
REQ-018 o_capture_reset  out  1  one-cycle capture-buffer reset pulse.
REQ-019 o_armed  out  1  high while state is ARMED.
REQ-020 o_busy  out  1  high while state is not IDLE.
REQ-021 o_trig_count  out  TCOUNT_W  triggers issued since reset, wraps to 0.

Function
REQ-022 States: IDLE, PRETRIG, ARMED, TRIGGERED, HOLDOFF; all outputs registered.
REQ-023 i_level, i_hysteresis, i_mode, i_pretrig_count and i_holdoff are latched on every entry to PRETRIG; later changes do not affect the run.
REQ-024 Schmitt flag: set on a valid sample >= level; cleared on a valid sample < level minus hysteresis, with that lower bound saturating at 0; otherwise held.
REQ-025 Flag updates on every valid sample in every state; a primed bit is cleared by reset and set by the first valid sample; no edge is qualified while unprimed.
REQ-026 Rising = flag 0->1; falling = flag 1->0; either = both; level-above = valid sample with flag set after update.
REQ-027 IDLE -> PRETRIG when i_arm=1; i_arm is ignored in all other states.
REQ-028 PRETRIG counts valid samples and -> ARMED the cycle the count reaches the latched pretrig value; a value of 0 goes to ARMED on the next cycle.
REQ-029 ARMED -> TRIGGERED on a qualifying valid sample; o_trigger pulses for exactly one cycle, one cycle after that sample; o_trig_count increments in the same cycle.
REQ-030 TRIGGERED holds until i_transfer_done, then -> HOLDOFF with o_capture_reset pulsed for one cycle.
REQ-031 HOLDOFF waits the latched holdoff number of cycles (0 = leave on the next cycle), then -> PRETRIG if i_auto_rearm=1, else IDLE.
REQ-032 i_transfer_done in PRETRIG or ARMED aborts: -> IDLE, o_capture_reset pulses; ignored in IDLE and HOLDOFF.
REQ-033 Same-cycle i_transfer_done and a qualifying sample in ARMED: the abort wins; no trigger, no count.
REQ-034 Samples arriving in TRIGGERED or HOLDOFF never produce a trigger.

Reset
REQ-035 i_reset=1: state IDLE; counters, Schmitt flag and primed bit cleared; all outputs 0 on the next edge.
REQ-036 Reset mid-run discards the run without pulsing o_trigger or o_capture_reset.

Structure
REQ-037 Package osc_trig_pkg holds the state enum, the i_mode encodings and the default parameter values.
REQ-038 The Schmitt flag and primed logic live in sub-module hysteresis_comparator; edge decode and the FSM remain in edge_trigger_unit.

Verification
REQ-039 Rising, level=1500, hyst=50, pretrig=0: samples 1400, 1501 -> o_trigger one cycle after 1501; o_trig_count=1.
REQ-040 Hysteresis: rising, level=1500, hyst=50, samples 1501, 1460, 1502 -> no second trigger until a sample below 1450 and then one >= 1500.
REQ-041 Pretrig=4: a qualifying edge on valid sample 3 -> no trigger; o_armed rises after the 4th valid sample.
REQ-042 Holdoff=10, auto_rearm=1: i_transfer_done in TRIGGERED -> o_capture_reset pulse; PRETRIG entered 11 cycles later.
REQ-043 ARMED with i_transfer_done and a qualifying sample in the same cycle -> IDLE, o_capture_reset=1, o_trigger=0, count unchanged.
REQ-044 i_reset asserted in TRIGGERED -> all outputs 0 and IDLE next cycle; o_trig_count=0.
